// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding and width helpers.
package reset_sequencer_pkg;

  localparam logic [1:0] RSTSEQ_HOLD    = 2'd0;
  localparam logic [1:0] RSTSEQ_RELEASE = 2'd1;
  localparam logic [1:0] RSTSEQ_RUN     = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD    = RSTSEQ_HOLD,
    ST_RELEASE = RSTSEQ_RELEASE,
    ST_RUN     = RSTSEQ_RUN
  } rstseq_state_e;

  // Interval counter width: must hold max(HOLD_CYCLES, GAP_CYCLES)-1; never below one bit.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int longest;
    int w;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    w       = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

  // Stage index width, one spare bit so the index can reach STAGES.
  function automatic int stage_width(input int stages);
    return $clog2(stages) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_cycle_timer.sv
// Clearable up-counter with a terminal-count flag, shared by the hold and gap intervals.
module reset_sequencer_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Count enabled cycles; a clear reloads zero and takes priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/reset_sequencer.sv
// Reset conditioner: stretches a reset request to a minimum hold time, then
// releases per-stage resets in thermometer order, one every GAP_CYCLES.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int SEQ_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic [STAGES-1:0]    rst_out,
  output logic                 busy,
  output logic [SEQ_CNT_W-1:0] seq_cnt
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int STG_W = stage_width(STAGES);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT  = CNT_W'(GAP_CYCLES - 1);

  generate
    if (STAGES < 1 || STAGES > 16 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SEQ_CNT_W < 1) begin : g_bad_params
      $error("reset_sequencer: illegal parameter value");
    end
  endgenerate

  rstseq_state_e        r_state;
  rstseq_state_e        w_next_state;
  logic [STAGES-1:0]    r_rst_out;
  logic [STAGES-1:0]    w_next_rst_out;
  logic [STG_W-1:0]     r_stage;
  logic [STG_W-1:0]     w_next_stage;
  logic                 r_busy;
  logic [SEQ_CNT_W-1:0] r_seq_cnt;
  logic                 w_tmr_clear;
  logic                 w_tmr_en;
  logic                 w_tc;
  logic                 w_seq_inc;
  logic [CNT_W-1:0]     w_limit;

  assign w_limit = (r_state == ST_HOLD) ? HOLD_LIMIT : GAP_LIMIT;

  reset_sequencer_cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_tmr_clear),
    .i_en    (w_tmr_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Next-state logic: a request always wins and restarts the whole sequence;
  // otherwise each terminal count shifts one more zero into the thermometer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_next_state   = r_state;
    w_next_rst_out = r_rst_out;
    w_next_stage   = r_stage;
    w_tmr_clear    = 1'b0;
    w_tmr_en       = 1'b1;
    w_seq_inc      = 1'b0;
    if (req) begin
      w_next_state   = ST_HOLD;
      w_next_rst_out = '1;
      w_next_stage   = '0;
      w_tmr_clear    = 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_tc) begin
            w_next_rst_out = r_rst_out << 1;
            w_tmr_clear    = 1'b1;
            if (STAGES == 1) begin
              w_next_state = ST_RUN;
              w_seq_inc    = 1'b1;
            end else begin
              w_next_state = ST_RELEASE;
              w_next_stage = STG_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (w_tc) begin
            w_next_rst_out = r_rst_out << 1;
            w_tmr_clear    = 1'b1;
            w_next_stage   = r_stage + 1'b1;
            if (r_stage == LAST_STAGE) begin
              w_next_state = ST_RUN;
              w_seq_inc    = 1'b1;
            end
          end
        end
        ST_RUN: begin
          w_tmr_en = 1'b0;
        end
        default: begin
          w_next_state   = ST_HOLD;
          w_next_rst_out = '1;
          w_next_stage   = '0;
          w_tmr_clear    = 1'b1;
        end
      endcase
    end
  end

  // State, thermometer, busy and sequence counter registers; all outputs come from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_HOLD;
      r_rst_out <= '1;
      r_stage   <= '0;
      r_busy    <= 1'b1;
      r_seq_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_rst_out <= w_next_rst_out;
      r_stage   <= w_next_stage;
      r_busy    <= |w_next_rst_out;
      if (w_seq_inc) begin
        r_seq_cnt <= r_seq_cnt + 1'b1;
      end
    end
  end

  assign rst_out = r_rst_out;
  assign busy    = r_busy;
  assign seq_cnt = r_seq_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a 1/1/1 corner
// instance, both compared every cycle against a time-since-trigger model.
module tb_reset_sequencer;

  localparam int SA = 3;
  localparam int HA = 16;
  localparam int GA = 4;
  localparam int SB = 1;
  localparam int HB = 1;
  localparam int GB = 1;
  localparam int AGE_CAP = 100000;

  logic       clk = 1'b0;
  logic       rst_a, req_a, rst_b, req_b;
  logic [2:0] out_a;
  logic       busy_a;
  logic [7:0] seq_a;
  logic [0:0] out_b;
  logic       busy_b;
  logic [7:0] seq_b;

  int n_tests = 0;
  int n_fail  = 0;
  int age_a = 0, age_b = 0;
  int mseq_a = 0, mseq_b = 0;

  always #5 clk = ~clk;

  reset_sequencer dut_a (
    .clk(clk), .rst(rst_a), .req(req_a),
    .rst_out(out_a), .busy(busy_a), .seq_cnt(seq_a)
  );

  reset_sequencer #(
    .STAGES(SB), .HOLD_CYCLES(HB), .GAP_CYCLES(GB), .SEQ_CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .rst_out(out_b), .busy(busy_b), .seq_cnt(seq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the age (edges since the last trigger): stage k is
  // released once age >= hold + k*gap.
  function automatic logic [15:0] exp_out(input int age, input int s, input int h, input int g);
    int          rel;
    logic [31:0] all_m;
    logic [31:0] rel_m;
    rel = (age < h) ? 0 : ((age - h) / g + 1);
    if (rel > s) rel = s;
    all_m = (32'd1 << s) - 1;
    rel_m = (32'd1 << rel) - 1;
    return 16'(all_m & ~rel_m);
  endfunction

  task automatic check_all(input string where);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = exp_out(age_a, SA, HA, GA);
    eb = exp_out(age_b, SB, HB, GB);
    check({where, "_rst_out_a"}, 32'(out_a), 32'(ea[2:0]));
    check({where, "_busy_a"}, 32'(busy_a), 32'(|ea[2:0]));
    check({where, "_seq_a"}, 32'(seq_a), 32'(mseq_a));
    check({where, "_rst_out_b"}, 32'(out_b), 32'(eb[0:0]));
    check({where, "_busy_b"}, 32'(busy_b), 32'(eb[0]));
    check({where, "_seq_b"}, 32'(seq_b), 32'(mseq_b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_a) begin
      age_a = 0; mseq_a = 0;
    end else if (req_a) begin
      age_a = 0;
    end else begin
      if (age_a < AGE_CAP) age_a++;
      if (age_a == HA + (SA - 1) * GA) mseq_a = (mseq_a + 1) % 256;
    end
    if (rst_b) begin
      age_b = 0; mseq_b = 0;
    end else if (req_b) begin
      age_b = 0;
    end else begin
      if (age_b < AGE_CAP) age_b++;
      if (age_b == HB + (SB - 1) * GB) mseq_b = (mseq_b + 1) % 256;
    end
    check_all("cyc");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert rst_a between edges, check the immediate effect, release two edges later.
  task automatic pulse_rst_a();
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    age_a = 0; mseq_a = 0;
    check("async_out_a", 32'(out_a), 32'h7);
    check("async_busy_a", 32'(busy_a), 32'h1);
    check("async_seq_a", 32'(seq_a), 32'h0);
    ticks(2);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic set_req_a(input logic v);
    @(negedge clk);
    req_a = v;
  endtask

  task automatic set_req_b(input logic v);
    @(negedge clk);
    req_b = v;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    #1;
    check_all("reset_state");
    ticks(3);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Power-on release timing.
    ticks(15);
    check("pwr_e15", 32'(out_a), 32'h7);
    tick();
    check("pwr_e16", 32'(out_a), 32'h6);
    check("pwr_b_seq", 32'(seq_b), 32'h1);
    ticks(4);
    check("pwr_e20", 32'(out_a), 32'h4);
    ticks(4);
    check("pwr_e24", 32'(out_a), 32'h0);
    check("pwr_busy", 32'(busy_a), 32'h0);
    check("pwr_seq", 32'(seq_a), 32'h1);
    ticks(6);

    // Single request pulse from RUN.
    set_req_a(1'b1);
    tick();
    check("req_out", 32'(out_a), 32'h7);
    check("req_busy", 32'(busy_a), 32'h1);
    set_req_a(1'b0);
    ticks(24);
    check("req_seq", 32'(seq_a), 32'h2);

    // Retrigger during RELEASE at edge 18.
    pulse_rst_a();
    ticks(17);
    check("retrig_e17", 32'(out_a), 32'h6);
    set_req_a(1'b1);
    tick();
    check("retrig_e18", 32'(out_a), 32'h7);
    set_req_a(1'b0);
    ticks(23);
    check("retrig_e41_seq", 32'(seq_a), 32'h0);
    tick();
    check("retrig_e42_out", 32'(out_a), 32'h0);
    check("retrig_e42_seq", 32'(seq_a), 32'h1);

    // Request held from edge 30 through 39.
    pulse_rst_a();
    ticks(29);
    set_req_a(1'b1);
    ticks(10);
    set_req_a(1'b0);
    ticks(15);
    check("held_e54", 32'(out_a), 32'h7);
    tick();
    check("held_e55", 32'(out_a), 32'h6);
    ticks(10);

    // Asynchronous reset between edges 21 and 22, then a clean power-on replay.
    pulse_rst_a();
    ticks(21);
    pulse_rst_a();
    ticks(24);
    check("async_replay_out", 32'(out_a), 32'h0);
    check("async_replay_seq", 32'(seq_a), 32'h1);

    // Corner instance: request at edge 5, then 256 back-to-back sequences.
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    age_b = 0; mseq_b = 0;
    check("b_async_out", 32'(out_b), 32'h1);
    tick();
    @(negedge clk);
    rst_b = 1'b0;
    tick();
    check("b_e1_out", 32'(out_b), 32'h0);
    check("b_e1_seq", 32'(seq_b), 32'h1);
    ticks(3);
    set_req_b(1'b1);
    tick();
    check("b_e5_out", 32'(out_b), 32'h1);
    set_req_b(1'b0);
    tick();
    check("b_e6_out", 32'(out_b), 32'h0);
    check("b_e6_seq", 32'(seq_b), 32'h2);
    for (int i = 0; i < 256; i++) begin
      set_req_b(1'b1);
      tick();
      set_req_b(1'b0);
      tick();
    end
    check("b_wrap_seq", 32'(seq_b), 32'h2);

    // Randomized requests, held requests and asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst_a) begin
        rst_a = ($urandom_range(0, 1) == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst_a = 1'b1;
        #1;
        age_a = 0; mseq_a = 0;
        check_all("rand_async");
      end
      req_a = req_a ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      req_b = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
